ps2_keypad_decoder: RTL
=======================

// Module: ps2_keypad_decoder
// PURPOSE
//  Receives PS/2 keyboard frames on the system clock. Ps2_clk is oversampled, not used as a clock.
//  Checks start, odd-parity and stop bits, and tracks E0 (extended) and F0 (break) prefixes.
//  Maps NUM_KEYS programmable scan codes to held-level and press-pulse outputs.
//  Sits between the board PS/2 pins and the game/control logic, e.g. direction keys and start.
// PARAMETERS
//  NUM_KEYS        5                       number of mapped keys (1..16)
//  KEY_MAP         {8'h4D,8'h23,8'h1B,8'h1C,8'h1D}  NUM_KEYS*8 packed codes; entry i = bits [8i+7:8i]
//  EXT_MASK        5'b00000                bit i=1: entry i matches only with E0 prefix, 0: only without
//  FILTER_LEN      8                       cycles a synchronised ps2_clk level must hold to be accepted
//  TIMEOUT_CYCLES  50000                   max cycles between filtered falling edges inside a frame
// PORTS
//  clk         in   1         system clock; all logic on posedge
//  rst_n       in   1         asynchronous active-low reset
//  ps2_clk     in   1         raw PS/2 clock pin (async)
//  ps2_data    in   1         raw PS/2 data pin (async)
//  key_down    out  NUM_KEYS  level: key i currently held
//  key_press   out  NUM_KEYS  1-cycle pulse: key i went from released to held
//  scan_code   out  8         last accepted non-prefix code
//  scan_ext    out  1         scan_code was preceded by E0
//  scan_break  out  1         scan_code was preceded by F0
//  scan_valid  out  1         1-cycle pulse: scan_code/scan_ext/scan_break updated
//  frame_err   out  1         1-cycle pulse: bad start/parity/stop bit or timeout
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; prefix flags clear; filtered clock = 1. Reset mid-frame discards it.
//  Input sync: 2-FF synchroniser on both pins.
//  Clock filter: filtered clock changes only after the synchronised value differs from it for
//   FILTER_LEN consecutive cycles. A 1->0 change of the filtered clock is a "fall".
//   Data is sampled from the synchronised ps2_data on the cycle the fall is detected.
//  Frame FSM: IDLE -> DATA(8 bits, LSB first) -> PARITY -> STOP -> IDLE.
//   IDLE: fall with data=0 -> DATA, bit count=0. Fall with data=1 -> frame_err, stay IDLE.
//   DATA: shift in bits; after the 8th bit -> PARITY.
//   PARITY: capture bit; frame valid only if (data ^ 8 data bits) has odd parity.
//   STOP: fall with data=1 and parity ok -> byte accepted. Otherwise frame_err. Either way -> IDLE.
//   Watchdog: in any non-IDLE state, TIMEOUT_CYCLES cycles without a fall -> frame_err, IDLE.
//   Watchdog counter clears on every fall and in IDLE.
//  Byte decode (cycle after the STOP fall, i.e. registered; latency 1 clk from stop-bit detection):
//   E0 -> set ext_pending; F0 -> set brk_pending. No scan_valid for prefixes.
//   Other code -> scan_valid=1; scan_code=code; scan_ext=ext_pending; scan_break=brk_pending;
//    then clear both pending flags.
//   Prefix order E0 F0 or F0 E0 accepted identically.
//   For each i with KEY_MAP[i]==code and EXT_MASK[i]==ext_pending:
//    make: key_down[i]<=1; key_press[i]<=1 only if key_down[i] was 0 (typematic repeats give no pulse).
//    break: key_down[i]<=0; no pulse.
//   Duplicate map entries: every matching i updates. Unmapped codes: only scan_* outputs update.
//   key_down/key_press change in the same cycle scan_valid is high.
//  Any frame_err also clears ext_pending and brk_pending; key_down is left unchanged.
//  key_press, scan_valid and frame_err are never high for more than one consecutive cycle.
// TESTING
//  1 W make: frame 0x1D, bits 0,1,0,1,1,1,0,0,0,0,1 at ~12 kHz
//    -> scan_valid with code 1D, ext=0, brk=0; key_press[0] pulse; key_down[0]=1.
//  2 Typematic: 0x1D x3, then F0 1D -> one key_press[0] only; key_down[0] stays 1 until the break,
//    then 0; scan_break=1 on the last scan_valid.
//  3 Extended: EXT_MASK[1]=1, KEY_MAP[1]=0x75; send E0 75, then plain 75 -> first sets key_down[1]
//    with scan_ext=1; second gives scan_valid with no key_down change.
//  4 Parity error: frame 0x1C with parity bit flipped -> frame_err pulse; no scan_valid;
//    following good 0x1C decodes normally.
//  5 Timeout/glitch: stop clocking after 4 data bits -> frame_err exactly TIMEOUT_CYCLES after the
//    last fall. A ps2_clk glitch shorter than FILTER_LEN gives no bit shift.
//  6 Reset: assert rst_n low mid-frame with key_down!=0 -> all outputs 0 asynchronously;
//    next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_keypad_decoder.sv
// PS/2 keyboard receiver on the system clock: oversampled and filtered ps2_clk, frame checking,
// E0/F0 prefix tracking and a programmable scan-code to key map with held/press outputs.
module ps2_keypad_decoder #(
    parameter int                    NUM_KEYS       = 5,
    parameter logic [NUM_KEYS*8-1:0] KEY_MAP        = {8'h4D, 8'h23, 8'h1B, 8'h1C, 8'h1D},
    parameter logic [NUM_KEYS-1:0]   EXT_MASK       = '0,
    parameter int                    FILTER_LEN     = 8,
    parameter int                    TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [7:0]          scan_code,
    output logic                scan_ext,
    output logic                scan_break,
    output logic                scan_valid,
    output logic                frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]          clk_sync_q, data_sync_q;
    logic                filt_clk_q, filt_clk_d;
    logic [FW-1:0]       filt_cnt_q, filt_cnt_d;
    logic [1:0]          state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_ok_q, par_ok_d;
    logic [WW-1:0]       wd_cnt_q, wd_cnt_d;
    logic                ext_pend_q, ext_pend_d;
    logic                brk_pend_q, brk_pend_d;
    logic [NUM_KEYS-1:0] key_down_q, key_down_d;
    logic [NUM_KEYS-1:0] key_press_q, key_press_d;
    logic [7:0]          scan_code_q, scan_code_d;
    logic                scan_ext_q, scan_ext_d;
    logic                scan_brk_q, scan_brk_d;
    logic                scan_valid_q, scan_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                clk_s, data_s, fall, byte_ok;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Filtered clock flips once the synchronised level has disagreed for FILTER_LEN cycles
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        fall       = 1'b0;
        if (clk_s != filt_clk_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_s;
                fall       = filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        key_down_d   = key_down_q;
        key_press_d  = '0;
        scan_code_d  = scan_code_q;
        scan_ext_d   = scan_ext_q;
        scan_brk_d   = scan_brk_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        byte_ok      = 1'b0;

        if (state_q == S_IDLE || fall) wd_cnt_d = '0;
        else                           wd_cnt_d = wd_cnt_q + WW'(1);

        case (state_q)
            S_IDLE: if (fall) begin
                if (!data_s) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            S_DATA: if (fall) begin
                shift_d   = {data_s, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: if (fall) begin
                par_ok_d = data_s ^ (^shift_q);
                state_d  = S_STOP;
            end
            default: if (fall) begin
                state_d = S_IDLE;
                if (data_s && par_ok_q) byte_ok = 1'b1;
                else                    frame_err_d = 1'b1;
            end
        endcase

        if (state_q != S_IDLE && !fall && wd_cnt_q == WW'(TIMEOUT_CYCLES - 1)) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
        end

        if (frame_err_d) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end

        // Accepted byte: prefixes only arm flags, any other code updates scan_* and the key map
        if (byte_ok) begin
            if (shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                scan_valid_d = 1'b1;
                scan_code_d  = shift_q;
                scan_ext_d   = ext_pend_q;
                scan_brk_d   = brk_pend_q;
                ext_pend_d   = 1'b0;
                brk_pend_d   = 1'b0;
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (KEY_MAP[8*i +: 8] == shift_q && EXT_MASK[i] == ext_pend_q) begin
                        if (brk_pend_q) begin
                            key_down_d[i] = 1'b0;
                        end else begin
                            key_press_d[i] = ~key_down_q[i];
                            key_down_d[i]  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            filt_clk_q   <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            par_ok_q     <= 1'b0;
            wd_cnt_q     <= '0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            key_down_q   <= '0;
            key_press_q  <= '0;
            scan_code_q  <= '0;
            scan_ext_q   <= 1'b0;
            scan_brk_q   <= 1'b0;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2_clk};
            data_sync_q  <= {data_sync_q[0], ps2_data};
            filt_clk_q   <= filt_clk_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            par_ok_q     <= par_ok_d;
            wd_cnt_q     <= wd_cnt_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            key_down_q   <= key_down_d;
            key_press_q  <= key_press_d;
            scan_code_q  <= scan_code_d;
            scan_ext_q   <= scan_ext_d;
            scan_brk_q   <= scan_brk_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Shift register holds data only; its contents are ignored until a frame completes
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign key_down   = key_down_q;
    assign key_press  = key_press_q;
    assign scan_code  = scan_code_q;
    assign scan_ext   = scan_ext_q;
    assign scan_break = scan_brk_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;
endmodule
